// File: rtl/uart_sram_tx_pkg.sv
// Shared types and defaults for the SRAM-to-UART dump path.
package uart_sram_tx_pkg;

  typedef enum logic [2:0] {
    S_UTX_IDLE,
    S_UTX_FETCH,
    S_UTX_LOAD,
    S_UTX_HI,
    S_UTX_LO
  } uart_sram_tx_state_type;

  // 50 MHz / 115200 baud
  localparam int UTX_CLKS_PER_BIT = 434;
  localparam int UTX_SRAM_RD_LAT  = 2;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser. A Load in the last cycle of a stop bit starts the next
// frame with no idle gap; Byte_done marks that last cycle.
module uart_byte_tx
  import uart_sram_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UTX_CLKS_PER_BIT
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Load,
  input  logic [7:0] Byte,
  output logic       TX,
  output logic       Byte_done,
  output logic       Tx_busy
);

  localparam int            CW       = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_idx;
  logic [8:0]    shreg;
  logic          active;
  logic          bit_end;

  assign bit_end   = active && (clk_cnt == BIT_LAST);
  assign Byte_done = bit_end && (bit_idx == 4'd9);
  assign Tx_busy   = active;

  // Frame control: bit-time counter, bit index (0 start, 1-8 data, 9 stop), line level
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      TX      <= 1'b1;
      active  <= 1'b0;
      clk_cnt <= '0;
      bit_idx <= '0;
    end else if (Load) begin
      TX      <= 1'b0;
      active  <= 1'b1;
      clk_cnt <= '0;
      bit_idx <= '0;
    end else if (active) begin
      if (bit_end) begin
        clk_cnt <= '0;
        if (bit_idx == 4'd9) begin
          active <= 1'b0;
          TX     <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          TX      <= shreg[0];
        end
      end else begin
        clk_cnt <= clk_cnt + CW'(1);
      end
    end
  end

  // Data bits plus stop bit, shifted out LSB first
  always_ff @(posedge Clock) begin
    if (Load) begin
      shreg <= {1'b1, Byte};
    end else if (bit_end && (bit_idx != 4'd9)) begin
      shreg <= {1'b1, shreg[8:1]};
    end
  end

endmodule

// File: rtl/uart_sram_tx.sv
// Streams a range of 16-bit SRAM words out on UART TX, high byte first.
// The next word is prefetched during the current high byte so frames run
// back-to-back.
module uart_sram_tx
  import uart_sram_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UTX_CLKS_PER_BIT,
  parameter int SRAM_RD_LAT  = UTX_SRAM_RD_LAT
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic [17:0] Start_address,
  input  logic [17:0] Word_count,
  output logic        Busy,
  output logic        Done,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic        SRAM_we_n,
  output logic        UART_TX_O
);

  localparam int            RW     = $clog2(SRAM_RD_LAT + 1);
  localparam logic [RW-1:0] RD_LAT = RW'(SRAM_RD_LAT);

  uart_sram_tx_state_type state, state_n;

  logic [17:0]   rem_q;
  logic [RW-1:0] rd_cnt;
  logic          rd_cap;
  logic          pf_vld;
  logic [15:0]   pf_data;
  logic [7:0]    word_lo_q;
  logic          done_q;
  logic          start_job;
  logic          issue_next;
  logic          load_word;
  logic          load_lo;
  logic          done_set;
  logic          byte_done;
  logic          tx_busy;
  logic [7:0]    byte_sel;

  assign start_job  = (state == S_UTX_IDLE) && Start && (Word_count != '0);
  assign rd_cap     = (rd_cnt == RW'(1));
  assign issue_next = load_word && (rem_q > 18'd1);
  assign byte_sel   = load_word ? pf_data[15:8] : word_lo_q;
  assign Busy       = (state != S_UTX_IDLE);
  assign Done       = done_q;
  assign SRAM_we_n  = 1'b1;

  // Next state, byte loads and the completion pulse
  always_comb begin
    state_n   = state;
    load_word = 1'b0;
    load_lo   = 1'b0;
    done_set  = 1'b0;
    case (state)
      S_UTX_IDLE: begin
        if (Start) begin
          if (Word_count != '0) state_n = S_UTX_FETCH;
          else                  done_set = 1'b1;
        end
      end
      S_UTX_FETCH: begin
        if (rd_cap) state_n = S_UTX_LOAD;
      end
      S_UTX_LOAD: begin
        if (pf_vld && !tx_busy) begin
          load_word = 1'b1;
          state_n   = S_UTX_HI;
        end
      end
      S_UTX_HI: begin
        if (byte_done) begin
          load_lo = 1'b1;
          state_n = S_UTX_LO;
        end
      end
      S_UTX_LO: begin
        // Reload inside the final stop-bit cycle when the prefetch is ready,
        // otherwise park in LOAD until it is.
        if (byte_done) begin
          if (rem_q == '0) begin
            state_n  = S_UTX_IDLE;
            done_set = 1'b1;
          end else if (pf_vld) begin
            load_word = 1'b1;
            state_n   = S_UTX_HI;
          end else begin
            state_n = S_UTX_LOAD;
          end
        end
      end
      default: state_n = S_UTX_IDLE;
    endcase
  end

  // State, address, word counter, read-latency timer and prefetch flag
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state        <= S_UTX_IDLE;
      SRAM_address <= '0;
      rem_q        <= '0;
      rd_cnt       <= '0;
      pf_vld       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= done_set;
      if (start_job) begin
        SRAM_address <= Start_address;
        rem_q        <= Word_count;
        rd_cnt       <= RD_LAT;
      end else begin
        if (issue_next) begin
          SRAM_address <= SRAM_address + 18'd1;
          rd_cnt       <= RD_LAT;
        end else if (rd_cnt != '0) begin
          rd_cnt <= rd_cnt - RW'(1);
        end
        if (load_word) rem_q <= rem_q - 18'd1;
      end
      if (rd_cap)         pf_vld <= 1'b1;
      else if (load_word) pf_vld <= 1'b0;
    end
  end

  // Prefetch buffer and the low byte held while the high byte is on the line
  always_ff @(posedge Clock) begin
    if (rd_cap)    pf_data   <= SRAM_read_data;
    if (load_word) word_lo_q <= pf_data[7:0];
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .Load     (load_word || load_lo),
    .Byte     (byte_sel),
    .TX       (UART_TX_O),
    .Byte_done(byte_done),
    .Tx_busy  (tx_busy)
  );

endmodule

// File: tb/tb_uart_sram_tx.sv
// Bench for uart_sram_tx: SRAM model, cycle-exact UART frame monitor and a
// job-level reference model built from the SRAM contents.
`timescale 1ns/1ps
module tb_uart_sram_tx;

  localparam int CPB   = 4;
  localparam int LAT   = 2;
  localparam int FRAME = 10 * CPB;

  logic        clock_50 = 1'b0;
  logic        resetn   = 1'b0;
  logic        start    = 1'b0;
  logic [17:0] start_address = '0;
  logic [17:0] word_count    = '0;
  logic        busy;
  logic        done;
  logic [17:0] sram_address;
  logic [15:0] sram_rd = '0;
  logic        sram_we_n;
  logic        uart_tx;

  logic [15:0] sram_mem [0:262143];

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  // monitor state
  int          mon_phase = -1;
  int          mon_idx;
  logic [9:0]  mon_bits;
  bit          mon_ok;
  int          frame_start;
  logic [7:0]  rx_q[$];
  int          start_q[$];
  bit          ok_q[$];
  logic [17:0] addr_q[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  bit          done_busy = 1'b0;
  bit          busy_seen = 1'b0;
  bit          we_bad = 1'b0;

  always #10 clock_50 = ~clock_50;

  always @(posedge clock_50) cyc <= cyc + 1;

  // SRAM read path: address launched at one edge, data usable at the second edge after
  always @(posedge clock_50) sram_rd <= sram_mem[sram_address];

  uart_sram_tx #(
    .CLKS_PER_BIT(CPB),
    .SRAM_RD_LAT (LAT)
  ) dut (
    .Clock         (clock_50),
    .Resetn        (resetn),
    .Start         (start),
    .Start_address (start_address),
    .Word_count    (word_count),
    .Busy          (busy),
    .Done          (done),
    .SRAM_address  (sram_address),
    .SRAM_read_data(sram_rd),
    .SRAM_we_n     (sram_we_n),
    .UART_TX_O     (uart_tx)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame decoder: every bit must hold for exactly CPB cycles
  always @(negedge clock_50) begin
    if (!resetn) begin
      mon_phase = -1;
    end else if (mon_phase < 0) begin
      if (uart_tx == 1'b0) begin
        mon_phase   = 0;
        frame_start = cyc;
        mon_ok      = 1'b1;
        mon_bits[0] = 1'b0;
      end
    end else begin
      mon_phase++;
      mon_idx = mon_phase / CPB;
      if (mon_phase % CPB == 0) mon_bits[mon_idx] = uart_tx;
      else if (uart_tx !== mon_bits[mon_idx]) mon_ok = 1'b0;
      if (mon_phase == FRAME - 1) begin
        rx_q.push_back(mon_bits[8:1]);
        start_q.push_back(frame_start);
        ok_q.push_back(mon_ok && (mon_bits[9] == 1'b1));
        mon_phase = -1;
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc  = cyc;
      done_busy = busy;
    end
    if (busy === 1'b1) begin
      busy_seen = 1'b1;
      if (addr_q.size() == 0 || addr_q[$] != sram_address) addr_q.push_back(sram_address);
    end
    if (sram_we_n !== 1'b1) we_bad = 1'b1;
  end

  task automatic clear_obs();
    rx_q.delete();
    start_q.delete();
    ok_q.delete();
    addr_q.delete();
    done_cnt  = 0;
    busy_seen = 1'b0;
    we_bad    = 1'b0;
  endtask

  task automatic run_job(input logic [17:0] a, input int n, input bit poke);
    logic [7:0]  exp_b[$];
    logic [17:0] exp_a[$];
    logic [17:0] ai;
    logic [17:0] addr_before;
    int p;
    int lim;
    int bad;
    for (int i = 0; i < n; i++) begin
      ai = a + 18'(i);
      exp_a.push_back(ai);
      exp_b.push_back(sram_mem[ai][15:8]);
      exp_b.push_back(sram_mem[ai][7:0]);
    end
    clear_obs();
    addr_before = sram_address;
    @(posedge clock_50); #1;
    start = 1'b1; start_address = a; word_count = 18'(n); p = cyc;
    @(posedge clock_50); #1;
    start = 1'b0; start_address = 18'($urandom); word_count = 18'($urandom);
    lim = 2 * FRAME * n + 20;
    for (int k = 0; k < lim && done_cnt == 0; k++) begin
      @(negedge clock_50);
      if (poke && k == 10) start = 1'b1;
      else if (poke && k == 11) start = 1'b0;
    end
    check_val("done_seen", 32'(done_cnt != 0), 32'd1);
    repeat (FRAME) @(negedge clock_50);
    check_val("done_count", 32'(done_cnt), 32'd1);
    check_val("busy_at_done", 32'(done_busy), 32'd0);
    check_val("we_n_high", 32'(we_bad), 32'd0);
    check_val("byte_count", 32'(rx_q.size()), 32'(2 * n));
    if (n == 0) begin
      check_val("zero_done_lat", 32'(done_cyc - p), 32'd1);
      check_val("zero_busy", 32'(busy_seen), 32'd0);
      check_val("zero_addr", 32'(sram_address), 32'(addr_before));
    end else begin
      for (int i = 0; i < 2 * n && i < rx_q.size(); i++) begin
        check_val($sformatf("byte%0d", i), 32'(rx_q[i]), 32'(exp_b[i]));
        check_val($sformatf("frame%0d", i), 32'(ok_q[i]), 32'd1);
      end
      if (start_q.size() > 0) begin
        check_val("first_start_lat", 32'(start_q[0] - p), 32'(LAT + 2));
        check_val("done_after_stop", 32'(done_cyc - start_q[0]), 32'(2 * FRAME * n));
      end
      bad = 0;
      for (int i = 1; i < start_q.size(); i++)
        if (start_q[i] - start_q[i-1] != FRAME) bad++;
      check_val("frame_gaps", 32'(bad), 32'd0);
      check_val("addr_count", 32'(addr_q.size()), 32'(n));
      for (int i = 0; i < n && i < addr_q.size(); i++)
        check_val($sformatf("addr%0d", i), 32'(addr_q[i]), 32'(exp_a[i]));
    end
  endtask

  task automatic fill_random(input logic [17:0] a, input int n);
    logic [17:0] ai;
    for (int i = 0; i < n; i++) begin
      ai = a + 18'(i);
      sram_mem[ai] = 16'($urandom);
    end
  endtask

  initial begin
    logic [17:0] ra;
    int found;

    // reset state
    repeat (3) @(negedge clock_50);
    check_val("rst_tx", 32'(uart_tx), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_addr", 32'(sram_address), 32'd0);
    check_val("rst_we_n", 32'(sram_we_n), 32'd1);
    resetn = 1'b1;
    repeat (2) @(negedge clock_50);

    // basic single word
    sram_mem[100] = 16'hA55A;
    run_job(18'd100, 1, 1'b0);

    // streaming four words
    for (int i = 0; i < 4; i++) begin
      ra = 18'd146944 + 18'(i);
      sram_mem[ra] = {8'(2 * i), 8'(2 * i + 1)};
    end
    run_job(18'd146944, 4, 1'b0);

    // address wrap
    fill_random(18'h3FFFE, 3);
    run_job(18'h3FFFE, 3, 1'b0);

    // zero count
    run_job(18'($urandom), 0, 1'b0);

    // Start while busy is ignored
    ra = 18'($urandom);
    fill_random(ra, 2);
    run_job(ra, 2, 1'b1);

    // reset during the data bits of the second byte
    ra = 18'd5000;
    sram_mem[ra]      = 16'h3C00;
    sram_mem[ra + 1]  = 16'h1234;
    clear_obs();
    @(posedge clock_50); #1;
    start = 1'b1; start_address = ra; word_count = 18'd2;
    @(posedge clock_50); #1;
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 4 * FRAME && found == 0; k++) begin
      @(negedge clock_50);
      if (rx_q.size() == 1 && mon_phase == 3 * CPB) found = 1;
    end
    check_val("reach_second_byte", 32'(found), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check_val("async_rst_tx", 32'(uart_tx), 32'd1);
    check_val("async_rst_busy", 32'(busy), 32'd0);
    check_val("async_rst_done", 32'(done), 32'd0);
    repeat (3) @(negedge clock_50);
    check_val("abandon_no_done", 32'(done_cnt), 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clock_50);
    sram_mem[18'd777] = 16'hC3E1;
    run_job(18'd777, 1, 1'b0);

    // randomized jobs
    for (int t = 0; t < 3; t++) begin
      ra = (t == 0) ? 18'h3FFFF : 18'($urandom);
      found = int'($urandom_range(1, 3));
      fill_random(ra, found);
      run_job(ra, found, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
